// File: rtl/blk_5b688d.sv
// -----------------------------------------------------------------------------
// blk_5b688d : direct-branch trace packer for the Nios II OCI trace path.
//
// Direct-branch outcome codes (2 bits each) are accumulated into a 30-bit
// buffer holding up to 15 codes. A buffer that fills up, or a partial buffer
// that is flushed (explicitly or when trace is switched off), becomes one
// 36-bit frame {type[1:0], count[3:0], buffer[29:0]}. That frame is offered
// through a one-entry valid/ready output register. Trace must never stall the
// CPU, so a frame that finds the output register occupied is dropped. The
// drop sets a sticky flag and increments a saturating counter.
//
// Ports:
//   clk           system clock, all state on rising edge
//   reset         asynchronous, active-high reset
//   trc_on        trace enable; dct_valid ignored while low
//   dct_valid     one direct branch retired this cycle
//   dct_code      2-bit outcome code for that branch
//   flush         force emission of any partial buffer
//   frame_ready   downstream accepts frame_data this cycle
//   overflow_clr  clears overflow sticky and drop counter
//   dct_buffer    live accumulation buffer, newest code in [1:0]
//   dct_count     number of codes currently in dct_buffer (0..14)
//   frame_valid   output register holds a frame
//   frame_data    {type[1:0], count[3:0], buffer[29:0]}
//   overflow      sticky: at least one frame dropped
//   drop_count    saturating count of dropped frames
// -----------------------------------------------------------------------------
module blk_5b688d #(
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trc_on,
  input  logic                  dct_valid,
  input  logic [1:0]            dct_code,
  input  logic                  flush,
  input  logic                  frame_ready,
  input  logic                  overflow_clr,
  output logic [29:0]           dct_buffer,
  output logic [3:0]            dct_count,
  output logic                  frame_valid,
  output logic [35:0]           frame_data,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam logic [1:0] TYPE_FULL  = 2'b10;
  localparam logic [1:0] TYPE_FLUSH = 2'b01;
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};
  localparam logic [DROP_CNT_W-1:0] DROP_ONE = {{(DROP_CNT_W-1){1'b0}}, 1'b1};

  logic [29:0]           buf_q,         buf_d;
  logic [3:0]            cnt_q,         cnt_d;
  logic                  trc_on_d_q,    trc_on_d_d;
  logic                  frame_valid_q, frame_valid_d;
  logic [35:0]           frame_data_q,  frame_data_d;
  logic                  overflow_q,    overflow_d;
  logic [DROP_CNT_W-1:0] drop_count_q,  drop_count_d;

  // Intermediate combinational terms
  logic        accept_s;
  logic [29:0] acc_buf_s;
  logic [3:0]  acc_cnt_s;
  logic        full_s;
  logic        flush_req_s;
  logic        emit_s;
  logic        out_free_s;
  logic [35:0] emit_frame_s;

  // Accumulation, emission and output-register next-state logic
  always_comb begin
    buf_d         = buf_q;
    cnt_d         = cnt_q;
    trc_on_d_d    = trc_on;
    frame_valid_d = frame_valid_q;
    frame_data_d  = frame_data_q;
    overflow_d    = overflow_q;
    drop_count_d  = drop_count_q;

    // A code arriving in the same cycle as a flush is included first.
    accept_s = trc_on & dct_valid;
    if (accept_s) begin
      acc_buf_s = {buf_q[27:0], dct_code};
      acc_cnt_s = cnt_q + 4'd1;
    end else begin
      acc_buf_s = buf_q;
      acc_cnt_s = cnt_q;
    end

    // Completing the 15th code wins over a same-cycle flush: one type-10 frame.
    full_s      = accept_s & (cnt_q == 4'd14);
    flush_req_s = flush | (trc_on_d_q & ~trc_on);
    emit_s      = full_s | (flush_req_s & (acc_cnt_s != 4'd0));

    if (full_s) begin
      emit_frame_s = {TYPE_FULL, acc_cnt_s, acc_buf_s};
    end else begin
      emit_frame_s = {TYPE_FLUSH, acc_cnt_s, acc_buf_s};
    end

    // The accumulator clears on every emission, whether stored or dropped.
    if (emit_s) begin
      buf_d = 30'd0;
      cnt_d = 4'd0;
    end else begin
      buf_d = acc_buf_s;
      cnt_d = acc_cnt_s;
    end

    // The output register is reusable in the same cycle it retires a frame.
    out_free_s = ~frame_valid_q | frame_ready;

    if (emit_s && out_free_s) begin
      frame_valid_d = 1'b1;
      frame_data_d  = emit_frame_s;
    end else if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end else begin
      frame_valid_d = frame_valid_q;
    end

    // A drop in the same cycle as a clear wins, leaving a count of one.
    if (emit_s && !out_free_s) begin
      overflow_d = 1'b1;
      if (overflow_clr) begin
        drop_count_d = DROP_ONE;
      end else if (drop_count_q != DROP_MAX) begin
        drop_count_d = drop_count_q + DROP_ONE;
      end else begin
        drop_count_d = drop_count_q;
      end
    end else if (overflow_clr) begin
      overflow_d   = 1'b0;
      drop_count_d = {DROP_CNT_W{1'b0}};
    end else begin
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
    end
  end

  // State registers, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q         <= 30'd0;
      cnt_q         <= 4'd0;
      trc_on_d_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_data_q  <= 36'd0;
      overflow_q    <= 1'b0;
      drop_count_q  <= {DROP_CNT_W{1'b0}};
    end else begin
      buf_q         <= buf_d;
      cnt_q         <= cnt_d;
      trc_on_d_q    <= trc_on_d_d;
      frame_valid_q <= frame_valid_d;
      frame_data_q  <= frame_data_d;
      overflow_q    <= overflow_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign dct_buffer  = buf_q;
  assign dct_count   = cnt_q;
  assign frame_valid = frame_valid_q;
  assign frame_data  = frame_data_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_count_q;

endmodule

// File: doc/blk_5b688d.md
Name: qsys_system_reduzido_nios2_qsys_0_nios2_oci_dct_packer

Overview:
Direct-branch trace packer for the Nios II OCI trace path. It collects 2-bit outcome codes for retired direct branches into a 30-bit accumulation buffer (15 codes) and publishes the live buffer and count on dct_buffer/dct_count, which the OCI test-bench stage consumes. It emits full or flushed partial frames through a one-entry valid/ready output register toward the trace FIFO. Trace never stalls the CPU, so a frame that cannot be stored is dropped and counted.

Parameters:
DROP_CNT_W, 8, width of the saturating dropped-frame counter

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
trc_on  input  1  trace enable; dct_valid is ignored while low
dct_valid  input  1  one direct branch retired this cycle
dct_code  input  2  outcome code for that branch (00 not-taken, 01 taken, 10/11 reserved, packed as-is)
flush  input  1  force emission of any partial buffer (indirect jump, exception, debug entry)
frame_ready  input  1  downstream accepts frame_data this cycle
overflow_clr  input  1  clears overflow sticky and drop counter
dct_buffer  output  30  live accumulation buffer, newest code in [1:0]
dct_count  output  4  number of codes in dct_buffer, 0..14
frame_valid  output  1  output register holds a frame
frame_data  output  36  {type[1:0], count[3:0], buffer[29:0]}
overflow  output  1  sticky: at least one frame dropped
drop_count  output  DROP_CNT_W  saturating count of dropped frames

Behaviour:
- Reset (async assert, sync-free release): dct_buffer=0, dct_count=0, frame_valid=0, frame_data=0, overflow=0, drop_count=0.
- Accept: trc_on && dct_valid -> dct_buffer <= {dct_buffer[27:0], dct_code}; dct_count <= dct_count+1. Visible one cycle after the accepting edge.
- Full: accepting with dct_count==14 completes 15 codes -> emit event, type=2'b10, count=15, buffer={old[27:0],code}; next cycle dct_buffer=0, dct_count=0.
- Flush: flush=1, or trc_on falling edge (registered trc_on_d=1, trc_on=0), with resulting count>0 -> emit event type=2'b01, count and buffer as they stand (right-aligned, upper bits zero); accumulation clears. With count 0, flush is a no-op (no empty frames).
- Simultaneous code and flush in one cycle: code is accepted first and included in the flushed frame. Code completing full plus flush in the same cycle -> a single type-10 frame.
- Emission target: output register is free if frame_valid==0 or frame_ready==1 in the emit cycle. If free -> frame_data/frame_valid load at the next edge (latency 1 cycle from completing edge). If not free -> frame dropped, held frame unchanged, overflow<=1, drop_count increments, saturating at all-ones. Accumulation clears either way.
- Handshake: frame_valid && frame_ready retires the frame; frame_valid falls next cycle unless a new emit loads in the same cycle (back-to-back, no bubble). frame_data is stable while frame_valid && !frame_ready.
- overflow_clr: clears overflow and drop_count next cycle; a drop in the same cycle wins (overflow=1, drop_count=1).
- trc_on low: dct_valid ignored, buffer holds until flushed by the falling-edge rule; a pending output frame still drains.
- Reset mid-operation: partial buffer and any held frame are discarded, with no emission.

Test Plan:
- Reset then 15 accepts of code 01, frame_ready=1 -> dct_count 1..14 then 0; one cycle after 15th accept, frame_valid=1, frame_data={2'b10,4'hF,30'h15555555}.
- 3 accepts (01,00,01) then flush -> frame_data={2'b01,4'h3,30'h00000011}, dct_count=0; a second flush with count 0 -> no frame.
- 14 accepts then 15th accept with flush in the same cycle -> exactly one type-10 frame, count 15.
- frame_ready=0, emit two full frames -> first held unchanged, overflow=1, drop_count=1; raise frame_ready -> first retires, frame_valid=0 next cycle.
- frame_ready held 0 across 300 drops -> drop_count saturates at 8'hFF; overflow_clr -> overflow=0, drop_count=0.
- 5 accepts then trc_on 1->0 -> partial type-01 frame, count 5; reset asserted mid-accumulation -> all outputs 0 immediately (async).
